// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF transmitter: preamble patterns,
// block length, channel-status bit positions and the sample-rate codes.
package spdif_pkg;

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  localparam int         FRAMES_PER_BLOCK = 192;
  localparam logic [7:0] FRM_LAST         = 8'(FRAMES_PER_BLOCK - 1);

  localparam logic [7:0] CS_BIT_CONSUMER = 8'd0;
  localparam logic [7:0] CS_BIT_COPY     = 8'd2;
  localparam logic [7:0] CS_BIT_FS       = 8'd24;

  localparam logic [3:0] CS_FS_44K1 = 4'b0000;
  localparam logic [3:0] CS_FS_48K  = 4'b0010;
  localparam logic [3:0] CS_FS_32K  = 4'b0011;

  typedef enum logic {ST_IDLE, ST_RUN} tx_state_e;
  typedef enum logic [1:0] {PRE_SEL_B, PRE_SEL_M, PRE_SEL_W} pre_sel_e;

  function automatic logic [7:0] preamble(input pre_sel_e sel);
    case (sel)
      PRE_SEL_B: return PRE_B;
      PRE_SEL_M: return PRE_M;
      default:   return PRE_W;
    endcase
  endfunction

  // Consumer status: bit 0 stays 0, copy permitted, fs code LSB in bit 24.
  function automatic logic chstat_bit(input logic [7:0] frm, input logic [3:0] fs);
    logic b;
    b = 1'b0;
    if (frm == CS_BIT_COPY) b = 1'b1;
    if (frm >= CS_BIT_FS && frm < CS_BIT_FS + 8'd4) b = fs[frm[1:0]];
    return b;
  endfunction

endpackage

// File: rtl/spdif_bmc_encoder.sv
// Biphase-mark line encoder: emits preamble patterns for half-cells 0..7 and
// BMC-coded slot bits afterwards, tracking the line level across subframes.
module spdif_bmc_encoder
  import spdif_pkg::*;
(
  input  logic       sck,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] hc,
  input  pre_sel_e   pre_sel,
  input  logic       slot_bit,
  output logic       spdif
);

  logic       pol_q;
  logic       pol;
  logic [7:0] pre;
  logic       spdif_d;

  // The preamble polarity is latched from the level left by the previous subframe.
  always_comb begin
    pol     = (hc == 6'd0) ? spdif : pol_q;
    pre     = preamble(pre_sel);
    spdif_d = 1'b0;
    if (run) begin
      if (hc < 6'd8)
        spdif_d = pre[3'd7 - hc[2:0]] ^ pol;
      else if (!hc[0])
        spdif_d = ~spdif;
      else
        spdif_d = spdif ^ slot_bit;
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      spdif <= 1'b0;
      pol_q <= 1'b0;
    end else begin
      spdif <= spdif_d;
      if (hc == 6'd0) pol_q <= spdif;
    end
  end

endmodule

// File: rtl/spdif_transmit.sv
// IEC 60958 consumer transmitter at 128 x fs. Optional SPDIF_CHSTAT_EN sends the
// consumer channel-status word in the C slot; otherwise C is always 0.
//
// state   | meaning
// IDLE    | line held low, counters at 0, waiting for the first sample
// RUN     | continuous frame transmission until reset
module spdif_transmit
  import spdif_pkg::*;
#(
  parameter int         SAMPLE_BITS = 24,
  parameter logic [3:0] CS_FS_CODE  = 4'b0010
) (
  input  logic        sck,
  input  logic        rst_n,
  input  logic [31:0] data_left,
  input  logic [31:0] data_right,
  input  logic        sample_valid,
  output logic        spdif,
  output logic        frame_start,
  output logic        block_start,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [23:0] AUDIO_MASK = ~((24'd1 << (24 - SAMPLE_BITS)) - 24'd1);

  tx_state_e   state_q, state_d;
  logic [5:0]  hc;
  logic        sub;
  logic [7:0]  frm;
  logic [23:0] hold_l, hold_r, aud_l, aud_r, cur;
  logic        fresh, v_bit, c_bit, parity, slot_bit, run, load;
  logic [4:0]  slot;
  pre_sel_e    pre_sel;
  logic        unused_bits;

  assign unused_bits = ^{data_left[7:0], data_right[7:0], CS_FS_CODE};

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && sample_valid) state_d = ST_RUN;
  end

  assign run  = (state_q == ST_RUN);
  assign load = run && (hc == 6'd0) && !sub;

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      hc  <= '0;
      sub <= 1'b0;
      frm <= '0;
    end else if (!run) begin
      hc  <= '0;
      sub <= 1'b0;
      frm <= '0;
    end else begin
      hc <= hc + 6'd1;
      if (hc == 6'd63) begin
        sub <= ~sub;
        if (sub) frm <= (frm == FRM_LAST) ? 8'd0 : frm + 8'd1;
      end
    end
  end

  // A strobe on the load cycle refills the hold after the copy, so it stays fresh.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      hold_l      <= '0;
      hold_r      <= '0;
      fresh       <= 1'b0;
      aud_l       <= '0;
      aud_r       <= '0;
      v_bit       <= 1'b0;
      frame_start <= 1'b0;
      block_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (sample_valid) begin
        hold_l <= data_left[31:8] & AUDIO_MASK;
        hold_r <= data_right[31:8] & AUDIO_MASK;
        fresh  <= 1'b1;
      end else if (load) begin
        fresh <= 1'b0;
      end
      if (load) begin
        aud_l <= hold_l;
        aud_r <= hold_r;
        v_bit <= !fresh;
      end
      frame_start <= load;
      block_start <= load && (frm == 8'd0);
      underrun    <= load && !fresh;
      overrun     <= sample_valid && fresh && !load;
    end
  end

  always_comb begin
`ifdef SPDIF_CHSTAT_EN
    c_bit = chstat_bit(frm, CS_FS_CODE);
`else
    c_bit = 1'b0;
`endif
    slot     = hc[5:1];
    cur      = sub ? aud_r : aud_l;
    parity   = ^{cur, v_bit, c_bit};
    slot_bit = 1'b0;
    if (slot >= 5'd4 && slot <= 5'd27)
      slot_bit = cur[slot - 5'd4];
    else if (slot == 5'd28)
      slot_bit = v_bit;
    else if (slot == 5'd30)
      slot_bit = c_bit;
    else if (slot == 5'd31)
      slot_bit = parity;
    pre_sel = sub ? PRE_SEL_W : ((frm == 8'd0) ? PRE_SEL_B : PRE_SEL_M);
  end

  spdif_bmc_encoder u_bmc (
    .sck      (sck),
    .rst_n    (rst_n),
    .run      (run),
    .hc       (hc),
    .pre_sel  (pre_sel),
    .slot_bit (slot_bit),
    .spdif    (spdif)
  );

endmodule

// File: tb/tb_spdif_transmit.sv
// Directed bench for spdif_transmit: captures whole frames off the line,
// decodes preambles and biphase slots, and checks against hand-derived values.
module tb_spdif_transmit;
  import spdif_pkg::*;

  logic        sck = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_left = '0, data_right = '0;
  logic        sample_valid = 1'b0;
  logic        spdif, frame_start, block_start, underrun, overrun;

  int passed = 0, fails = 0, total = 0;
  logic [127:0] h;
  logic         prev_level;
  int n_under, n_over, n_block, n_fs;
  logic [23:0] last_l, last_r, nl, nr;
  logic        any;

  always #5 sck = ~sck;

  spdif_transmit #(.SAMPLE_BITS(24), .CS_FS_CODE(4'b0000)) dut (
    .sck          (sck),
    .rst_n        (rst_n),
    .data_left    (data_left),
    .data_right   (data_right),
    .sample_valid (sample_valid),
    .spdif        (spdif),
    .frame_start  (frame_start),
    .block_start  (block_start),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pre_of(input logic [63:0] hh, input logic prev);
    logic [7:0] p;
    for (int j = 0; j < 8; j++) p[7-j] = hh[j] ^ prev;
    return p;
  endfunction

  function automatic logic [31:0] slots_of(input logic [63:0] hh);
    logic [31:0] s;
    s = '0;
    for (int k = 4; k < 32; k++) s[k] = hh[2*k] ^ hh[2*k+1];
    return s;
  endfunction

  function automatic logic bmc_ok(input logic [63:0] hh);
    logic ok;
    ok = 1'b1;
    for (int k = 4; k < 32; k++) if (hh[2*k] == hh[2*k-1]) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic exp_c(input int f);
`ifdef SPDIF_CHSTAT_EN
    return (f % 192) == 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_frame();
    int k;
    k = 0;
    while (frame_start !== 1'b1 && k < 400) begin
      @(negedge sck);
      k++;
    end
    if (frame_start !== 1'b1) chk("frame_start_timeout", 32'(frame_start), 32'd1);
  endtask

  // Captures one 128-half-cell frame, optionally strobing samples at two offsets.
  task automatic capture(input int p1, input logic [31:0] l1, input logic [31:0] r1,
                         input int p2, input logic [31:0] l2, input logic [31:0] r2);
    wait_frame();
    n_under = 0; n_over = 0; n_block = 0; n_fs = 0;
    for (int i = 0; i < 128; i++) begin
      h[i] = spdif;
      n_under += int'(underrun);
      n_over  += int'(overrun);
      n_block += int'(block_start);
      n_fs    += int'(frame_start);
      if (i == p1) begin
        data_left = l1; data_right = r1; sample_valid = 1'b1;
      end else if (i == p2) begin
        data_left = l2; data_right = r2; sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      @(negedge sck);
    end
    sample_valid = 1'b0;
  endtask

  task automatic check_sub(input string nm, input logic [63:0] hh, input logic prev,
                           input logic [7:0] pre, input logic [23:0] aud,
                           input logic v, input logic c);
    logic [31:0] s;
    s = slots_of(hh);
    chk({nm, ".pre"}, 32'(pre_of(hh, prev)), 32'(pre));
    chk({nm, ".audio"}, 32'(s[27:4]), 32'(aud));
    chk({nm, ".v"}, 32'(s[28]), 32'(v));
    chk({nm, ".u"}, 32'(s[29]), 32'd0);
    chk({nm, ".c"}, 32'(s[30]), 32'(c));
    chk({nm, ".parity"}, 32'(^s[31:4]), 32'd0);
    chk({nm, ".bmc"}, 32'(bmc_ok(hh)), 32'd1);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] pl, input logic [23:0] el,
                             input logic [23:0] er, input logic ev, input int f);
    check_sub({nm, ".L"}, h[63:0], prev_level, pl, el, ev, exp_c(f));
    check_sub({nm, ".R"}, h[127:64], h[63], PRE_W, er, ev, exp_c(f));
    chk({nm, ".fs_cnt"}, 32'(n_fs), 32'd1);
    prev_level = h[127];
  endtask

  initial begin
    prev_level = 1'b0;
    repeat (3) @(negedge sck);
    chk("rst.spdif", 32'(spdif), 32'd0);
    chk("rst.pulses", 32'({frame_start, block_start, underrun, overrun}), 32'd0);
    rst_n = 1'b1;

    any = 1'b0;
    repeat (500) begin
      @(negedge sck);
      any |= spdif | frame_start | block_start | underrun | overrun;
    end
    chk("idle_quiet", 32'(any), 32'd0);

    data_left = 32'h12345600; data_right = 32'hABCDEF00; sample_valid = 1'b1;
    @(negedge sck);
    sample_valid = 1'b0;
    chk("lat1.frame_start", 32'(frame_start), 32'd0);
    @(negedge sck);
    chk("lat2.frame_start", 32'(frame_start), 32'd1);
    chk("lat2.spdif", 32'(spdif), 32'd1);

    capture(10, 32'h12345600, 32'hABCDEF00, -1, '0, '0);
    check_frame("f0", PRE_B, 24'h123456, 24'hABCDEF, 1'b0, 0);
    chk("f0.block", 32'(n_block), 32'd1);
    chk("f0.under", 32'(n_under), 32'd0);

    capture(100, 32'h80000100, 32'h7FFFFF00, -1, '0, '0);
    check_frame("f1", PRE_M, 24'h123456, 24'hABCDEF, 1'b0, 1);
    chk("f1.block", 32'(n_block), 32'd0);
    chk("f1.over", 32'(n_over), 32'd0);

    capture(-1, '0, '0, -1, '0, '0);
    check_frame("f2", PRE_M, 24'h800001, 24'h7FFFFF, 1'b0, 2);
    chk("f2.under", 32'(n_under), 32'd0);

    capture(10, 32'h00000100, 32'hFFFFFF00, 60, 32'h00000200, 32'h00000400);
    check_frame("f3", PRE_M, 24'h800001, 24'h7FFFFF, 1'b1, 3);
    chk("f3.under", 32'(n_under), 32'd1);
    chk("f3.over", 32'(n_over), 32'd1);

    capture(20, 32'h00000300, 32'h00AA5500, 127, 32'h00000400, 32'h00F0F000);
    check_frame("f4", PRE_M, 24'h000002, 24'h000004, 1'b0, 4);
    chk("f4.under", 32'(n_under), 32'd0);
    chk("f4.over", 32'(n_over), 32'd0);

    capture(-1, '0, '0, -1, '0, '0);
    check_frame("f5", PRE_M, 24'h000003, 24'h00AA55, 1'b0, 5);
    chk("f5.over", 32'(n_over), 32'd0);
    chk("f5.under", 32'(n_under), 32'd0);

    capture(64, 32'h00000500, 32'h00000600, -1, '0, '0);
    check_frame("f6", PRE_M, 24'h000004, 24'h00F0F0, 1'b0, 6);
    chk("f6.under", 32'(n_under), 32'd0);
    last_l = 24'h000005; last_r = 24'h000006;

    for (int f = 7; f < 200; f++) begin
      nl = 24'(f * 32'h010203);
      nr = ~nl;
      capture(f % 100 + 5, {nl, 8'h00}, {nr, 8'h00}, -1, '0, '0);
      check_frame($sformatf("f%0d", f), ((f % 192) == 0) ? PRE_B : PRE_M,
                  last_l, last_r, 1'b0, f);
      chk($sformatf("f%0d.block", f), 32'(n_block), ((f % 192) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("f%0d.under", f), 32'(n_under), 32'd0);
      last_l = nl; last_r = nr;
    end

    wait_frame();
    repeat (36) @(negedge sck);
    rst_n = 1'b0;
    #1;
    chk("midrst.spdif", 32'(spdif), 32'd0);
    chk("midrst.pulses", 32'({frame_start, block_start, underrun, overrun}), 32'd0);
    @(negedge sck);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (200) begin
      @(negedge sck);
      any |= spdif | frame_start | block_start | underrun | overrun;
    end
    chk("midrst.idle_quiet", 32'(any), 32'd0);

    prev_level = 1'b0;
    data_left = 32'hFEDCBA00; data_right = 32'h01234500; sample_valid = 1'b1;
    @(negedge sck);
    sample_valid = 1'b0;
    @(negedge sck);
    chk("relat.frame_start", 32'(frame_start), 32'd1);
    capture(-1, '0, '0, -1, '0, '0);
    check_frame("rf0", PRE_B, 24'hFEDCBA, 24'h012345, 1'b0, 0);
    chk("rf0.block", 32'(n_block), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
